// File: rtl/nonce_batch_sched.sv
// nonce_batch_sched
//   Sequences NUM_CORES lock-stepped SHA-256 double-hash cores over NUM_NONCES
//   nonces, NUM_CORES nonces per batch. Per batch: launch the cores, stream the
//   message read addresses and the shared round counter while they run, then
//   capture every core's result word and write the words back one per cycle.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   start               job request (accepted only when idle)
//   message_addr        base address of the message words (sampled on start)
//   output_addr         base address of the result area (sampled on start)
//   mem_addr/mem_we/mem_write_data   shared memory port (read or write)
//   done                one-cycle pulse at job completion
//   core_start          one-cycle launch pulse to all cores
//   core_tnew           shared round counter (1..64, 0 only in reset)
//   core_nonce          per-core nonce, 32 bits per core
//   core_read/core_comp phase flags from core 0
//   core_done/core_h    per-core done level and result word
module nonce_batch_sched #(
   parameter int unsigned NUM_CORES  = 8,
   parameter int unsigned NUM_NONCES = 16,
   parameter int unsigned MSG_WORDS  = 19
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      start,
   input  logic [15:0]               message_addr,
   input  logic [15:0]               output_addr,
   output logic [15:0]               mem_addr,
   output logic                      mem_we,
   output logic [31:0]               mem_write_data,
   output logic                      done,
   output logic                      core_start,
   output logic [6:0]                core_tnew,
   output logic [32*NUM_CORES-1:0]   core_nonce,
   input  logic                      core_read,
   input  logic                      core_comp,
   input  logic [NUM_CORES-1:0]      core_done,
   input  logic [32*NUM_CORES-1:0]   core_h
);

   localparam int unsigned NUM_BATCHES = NUM_NONCES / NUM_CORES;
   localparam int unsigned KW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam int unsigned WW = (MSG_WORDS > 1) ? $clog2(MSG_WORDS) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_RUN,
      S_COLLECT,
      S_WRITE,
      S_FINISH
   } state_t;

   state_t                          state_q, state_d;
   logic [31:0]                     batch_q, batch_d;
   logic [WW-1:0]                   word_idx_q, word_idx_d;
   logic [KW-1:0]                   wr_idx_q, wr_idx_d;
   logic [15:0]                     msg_base_q, msg_base_d;
   logic [15:0]                     out_ptr_q, out_ptr_d;
   logic [6:0]                      tnew_q, tnew_d;
   logic [NUM_CORES-1:0][31:0]      nonce_q, nonce_d;
   logic [NUM_CORES-1:0][31:0]      res_q, res_d;
   logic [31:0]                     nonce_base;

   assign core_tnew  = tnew_q;
   assign core_nonce = nonce_q;

   always_comb begin
      state_d        = state_q;
      batch_d        = batch_q;
      word_idx_d     = word_idx_q;
      wr_idx_d       = wr_idx_q;
      msg_base_d     = msg_base_q;
      out_ptr_d      = out_ptr_q;
      nonce_d        = nonce_q;
      res_d          = res_q;
      nonce_base     = '0;
      mem_addr       = '0;
      mem_we         = 1'b0;
      mem_write_data = '0;
      done           = 1'b0;
      core_start     = 1'b0;

      // Round counter runs in every state so it idles at 1 between passes.
      tnew_d = (core_comp && (tnew_q != 7'd64)) ? tnew_q + 7'd1 : 7'd1;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               msg_base_d = message_addr;
               out_ptr_d  = output_addr;
               batch_d    = '0;
               for (int unsigned i = 0; i < NUM_CORES; i++) begin
                  nonce_d[i] = 32'(i);
               end
               state_d = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            core_start = 1'b1;
            word_idx_d = '0;
            state_d    = S_RUN;
         end
         S_RUN: begin
            mem_addr = msg_base_q + 16'(word_idx_q);
            if (core_read && (word_idx_q != WW'(MSG_WORDS - 1))) begin
               word_idx_d = word_idx_q + WW'(1);
            end
            if (&core_done) begin
               state_d = S_COLLECT;
            end
         end
         S_COLLECT: begin
            res_d    = core_h;
            wr_idx_d = '0;
            state_d  = S_WRITE;
         end
         S_WRITE: begin
            // out_ptr advances once per written word, so across batches it
            // always equals output_addr + batch*NUM_CORES + k.
            mem_we         = 1'b1;
            mem_addr       = out_ptr_q;
            mem_write_data = res_q[wr_idx_q];
            out_ptr_d      = out_ptr_q + 16'd1;
            wr_idx_d       = wr_idx_q + KW'(1);
            if (wr_idx_q == KW'(NUM_CORES - 1)) begin
               if ((batch_q + 32'd1) < NUM_BATCHES) begin
                  batch_d    = batch_q + 32'd1;
                  nonce_base = (batch_q + 32'd1) * NUM_CORES;
                  for (int unsigned i = 0; i < NUM_CORES; i++) begin
                     nonce_d[i] = nonce_base + 32'(i);
                  end
                  state_d = S_LAUNCH;
               end else begin
                  state_d = S_FINISH;
               end
            end
         end
         S_FINISH: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         batch_q    <= '0;
         word_idx_q <= '0;
         wr_idx_q   <= '0;
         msg_base_q <= '0;
         out_ptr_q  <= '0;
         tnew_q     <= '0;
         nonce_q    <= '0;
         res_q      <= '0;
      end else begin
         state_q    <= state_d;
         batch_q    <= batch_d;
         word_idx_q <= word_idx_d;
         wr_idx_q   <= wr_idx_d;
         msg_base_q <= msg_base_d;
         out_ptr_q  <= out_ptr_d;
         tnew_q     <= tnew_d;
         nonce_q    <= nonce_d;
         res_q      <= res_d;
      end
   end

endmodule

// File: tb/tb_nonce_batch_sched.sv
// Directed bench for nonce_batch_sched (8 cores, 16 nonces, 19 message words).
// A behavioural core model reads for 22 cycles, computes for 64 cycles and
// raises done 87 cycles after core_start; core 7 can be delayed by extra7.
module tb_nonce_batch_sched;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          start;
   logic [15:0]   message_addr;
   logic [15:0]   output_addr;
   logic [15:0]   mem_addr;
   logic          mem_we;
   logic [31:0]   mem_write_data;
   logic          done;
   logic          core_start;
   logic [6:0]    core_tnew;
   logic [255:0]  core_nonce;
   logic          core_read;
   logic          core_comp;
   logic [7:0]    core_done;
   logic [255:0]  core_h;

   int unsigned   n_tests = 0;
   int unsigned   n_fail  = 0;

   nonce_batch_sched #(
      .NUM_CORES (8),
      .NUM_NONCES(16),
      .MSG_WORDS (19)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start),
      .message_addr  (message_addr),
      .output_addr   (output_addr),
      .mem_addr      (mem_addr),
      .mem_we        (mem_we),
      .mem_write_data(mem_write_data),
      .done          (done),
      .core_start    (core_start),
      .core_tnew     (core_tnew),
      .core_nonce    (core_nonce),
      .core_read     (core_read),
      .core_comp     (core_comp),
      .core_done     (core_done),
      .core_h        (core_h)
   );

   always #5 clk = ~clk;

   // ---------------- core model ----------------
   logic [31:0]   mcnt;
   logic          mact;
   int unsigned   extra7 = 0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mcnt <= '0;
         mact <= 1'b0;
      end else if (core_start) begin
         mcnt <= 32'd1;
         mact <= 1'b1;
      end else if (mact) begin
         mcnt <= mcnt + 32'd1;
      end
   end

   always_comb begin
      core_read = mact && (mcnt >= 32'd1) && (mcnt <= 32'd22);
      core_comp = mact && (mcnt >= 32'd23) && (mcnt <= 32'd86);
      core_done = '0;
      core_h    = '0;
      for (int i = 0; i < 8; i++) begin
         if (mact && (mcnt >= ((i == 7) ? 32'd87 + extra7 : 32'd87))) core_done[i] = 1'b1;
         core_h[i*32 +: 32] = core_done[i] ? 32'hA000_0000 + core_nonce[i*32 +: 32]
                                           : 32'h0BAD_0000 + 32'(i);
      end
   end

   // ---------------- per-cycle log ----------------
   logic [15:0]   log_addr [0:1023];
   logic          log_we   [0:1023];
   logic [31:0]   log_data [0:1023];
   logic          log_done [0:1023];
   logic          log_cs   [0:1023];
   logic [6:0]    log_tnew [0:1023];
   logic [255:0]  launch_nonce [0:3];
   int unsigned   n_we, n_done, n_launch;

   // Cycle 0 of the log is the cycle after the one in which start was high.
   task automatic record(input int unsigned budget, input bit restart_on_done);
      int unsigned post;
      bit seen;
      n_we = 0; n_done = 0; n_launch = 0; post = 0; seen = 0;
      for (int unsigned c = 0; (c < budget) && (c < 1024) && (post < 12); c++) begin
         @(negedge clk);
         log_addr[c] = mem_addr;
         log_we[c]   = mem_we;
         log_data[c] = mem_write_data;
         log_done[c] = done;
         log_cs[c]   = core_start;
         log_tnew[c] = core_tnew;
         if (core_start && (n_launch < 4)) begin
            launch_nonce[n_launch] = core_nonce;
            n_launch++;
         end
         if (mem_we) n_we++;
         if (done) n_done++;
         start = restart_on_done && done;
         if (seen) post++;
         if (done) seen = 1'b1;
      end
      start = 1'b0;
   endtask

   task automatic test_reset;
      reset_n = 1'b0; start = 1'b0; message_addr = '0; output_addr = '0;
      repeat (3) @(negedge clk);
      n_tests++; if (mem_addr !== 16'h0) begin n_fail++; $display("FAIL rst_mem_addr got %h exp 0000", mem_addr); end
      n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we got %b exp 0", mem_we); end
      n_tests++; if (mem_write_data !== 32'h0) begin n_fail++; $display("FAIL rst_wdata got %h exp 0", mem_write_data); end
      n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b exp 0", done); end
      n_tests++; if (core_start !== 1'b0) begin n_fail++; $display("FAIL rst_core_start got %b exp 0", core_start); end
      n_tests++; if (core_tnew !== 7'd0) begin n_fail++; $display("FAIL rst_tnew got %0d exp 0", core_tnew); end
      n_tests++; if (core_nonce !== 256'h0) begin n_fail++; $display("FAIL rst_nonce got %h exp 0", core_nonce); end
      reset_n = 1'b1;
      @(negedge clk);
      n_tests++; if (core_tnew !== 7'd1) begin n_fail++; $display("FAIL idle_tnew got %0d exp 1", core_tnew); end
      n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL idle_we got %b exp 0", mem_we); end
      n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL idle_done got %b exp 0", done); end
   endtask

   task automatic test_round_counter;
      logic [6:0] max_t;
      extra7 = 0;
      @(negedge clk); message_addr = 16'h0800; output_addr = 16'h0300; start = 1'b1;
      record(400, 1'b0);
      n_tests++; if (n_done !== 1) begin n_fail++; $display("FAIL rc_done_count got %0d exp 1", n_done); end
      for (int unsigned j = 0; j < 64; j++) begin
         n_tests++;
         if (log_tnew[23+j] !== 7'(j + 1)) begin
            n_fail++; $display("FAIL rc_tnew cycle %0d got %0d exp %0d", 23 + j, log_tnew[23+j], j + 1);
         end
      end
      n_tests++; if (log_tnew[87] !== 7'd1) begin n_fail++; $display("FAIL rc_wrap got %0d exp 1", log_tnew[87]); end
      n_tests++; if (log_tnew[22] !== 7'd1) begin n_fail++; $display("FAIL rc_pre got %0d exp 1", log_tnew[22]); end
      max_t = '0;
      for (int unsigned c = 0; c < 200; c++) if (log_tnew[c] > max_t) max_t = log_tnew[c];
      n_tests++; if (max_t !== 7'd64) begin n_fail++; $display("FAIL rc_max got %0d exp 64", max_t); end
   endtask

   task automatic test_multi_batch;
      logic [15:0] exp_a;
      extra7 = 0;
      @(negedge clk); message_addr = 16'h1000; output_addr = 16'h0040; start = 1'b1;
      record(400, 1'b1);   // also raises start during the done cycle
      n_tests++; if (n_done !== 1) begin n_fail++; $display("FAIL mb_done_count got %0d exp 1", n_done); end
      n_tests++; if (log_done[194] !== 1'b1) begin n_fail++; $display("FAIL mb_done_cycle got %b exp 1", log_done[194]); end
      n_tests++; if (n_we !== 16) begin n_fail++; $display("FAIL mb_we_count got %0d exp 16", n_we); end
      n_tests++; if (n_launch !== 2) begin n_fail++; $display("FAIL mb_launch_count got %0d exp 2", n_launch); end
      n_tests++; if (log_cs[97] !== 1'b1) begin n_fail++; $display("FAIL mb_launch2_cycle got %b exp 1", log_cs[97]); end
      for (int unsigned k = 0; k < 24; k++) begin
         exp_a = 16'h1000 + ((k < 18) ? 16'(k) : 16'd18);
         n_tests++;
         if (log_addr[1+k] !== exp_a) begin
            n_fail++; $display("FAIL mb_read_addr k=%0d got %h exp %h", k, log_addr[1+k], exp_a);
         end
      end
      for (int unsigned b = 0; b < 2; b++) begin
         for (int unsigned i = 0; i < 8; i++) begin
            n_tests++;
            if (launch_nonce[b][i*32 +: 32] !== 32'(8*b + i)) begin
               n_fail++; $display("FAIL mb_nonce b=%0d i=%0d got %0d exp %0d", b, i, launch_nonce[b][i*32 +: 32], 8*b + i);
            end
         end
      end
      for (int unsigned j = 0; j < 16; j++) begin
         int unsigned c;
         c = (j < 8) ? 89 + j : 186 + j - 8;
         n_tests++;
         if ((log_we[c] !== 1'b1) || (log_addr[c] !== 16'h0040 + 16'(j)) || (log_data[c] !== 32'hA000_0000 + j)) begin
            n_fail++; $display("FAIL mb_write j=%0d got we=%b a=%h d=%h exp we=1 a=%h d=%h",
                               j, log_we[c], log_addr[c], log_data[c], 16'h0040 + 16'(j), 32'hA000_0000 + j);
         end
      end
   endtask

   task automatic test_staggered_done;
      extra7 = 10;
      @(negedge clk); message_addr = 16'h1100; output_addr = 16'h0080; start = 1'b1;
      record(500, 1'b0);
      n_tests++; if (n_done !== 1) begin n_fail++; $display("FAIL st_done_count got %0d exp 1", n_done); end
      n_tests++; if (log_we[98] !== 1'b0) begin n_fail++; $display("FAIL st_we_early got %b exp 0", log_we[98]); end
      n_tests++; if (log_we[99] !== 1'b1) begin n_fail++; $display("FAIL st_we_first got %b exp 1", log_we[99]); end
      n_tests++; if (log_data[106] !== 32'hA000_0007) begin n_fail++; $display("FAIL st_core7_data got %h exp a0000007", log_data[106]); end
      n_tests++; if (log_addr[206] !== 16'h0088) begin n_fail++; $display("FAIL st_b1_addr got %h exp 0088", log_addr[206]); end
      n_tests++; if (log_done[214] !== 1'b1) begin n_fail++; $display("FAIL st_done_cycle got %b exp 1", log_done[214]); end
      extra7 = 0;
   endtask

   task automatic test_reset_mid_run;
      @(negedge clk); message_addr = 16'h2000; output_addr = 16'h0100; start = 1'b1;
      record(7, 1'b0);
      n_tests++; if (log_addr[6] !== 16'h2005) begin n_fail++; $display("FAIL mr_word5 got %h exp 2005", log_addr[6]); end
      reset_n = 1'b0;
      #1;
      n_tests++; if (mem_addr !== 16'h0) begin n_fail++; $display("FAIL mr_rst_addr got %h exp 0000", mem_addr); end
      n_tests++; if (core_tnew !== 7'd0) begin n_fail++; $display("FAIL mr_rst_tnew got %0d exp 0", core_tnew); end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      record(150, 1'b0);
      n_tests++; if (n_we !== 0) begin n_fail++; $display("FAIL mr_no_writes got %0d exp 0", n_we); end
      n_tests++; if (n_done !== 0) begin n_fail++; $display("FAIL mr_no_done got %0d exp 0", n_done); end
      n_tests++; if (n_launch !== 0) begin n_fail++; $display("FAIL mr_no_launch got %0d exp 0", n_launch); end
      @(negedge clk); message_addr = 16'h3000; output_addr = 16'h0200; start = 1'b1;
      record(400, 1'b0);
      n_tests++; if (log_addr[1] !== 16'h3000) begin n_fail++; $display("FAIL mr_reread got %h exp 3000", log_addr[1]); end
      n_tests++; if (log_addr[89] !== 16'h0200) begin n_fail++; $display("FAIL mr_first_wr got %h exp 0200", log_addr[89]); end
      n_tests++; if (n_we !== 16) begin n_fail++; $display("FAIL mr_we_count got %0d exp 16", n_we); end
      n_tests++; if (n_done !== 1) begin n_fail++; $display("FAIL mr_done_count got %0d exp 1", n_done); end
   endtask

   initial begin
      test_reset();
      test_round_counter();
      test_multi_batch();
      test_staggered_done();
      test_reset_mid_run();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog");
   end

endmodule
